// File: rtl/mem_stage.sv
// Memory stage: turns LOAD/STORE ops into a sequence of single-byte transfers
// on a byte-wide memory port, stalling upstream until the access finishes, then
// presents the assembled load result (or a null writeback for stores) for one cycle.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Fields captured at accept time and held for the whole access.
    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wd;
        logic        wreg;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d;

    logic        is_load, is_store, ld_ok, st_ok;
    logic [1:0]  last_idx;
    logic [31:0] ld_result;

    // Opcode / funct3 decode of the incoming EX op.
    always_comb begin
        is_load  = (op_i == OP_LOAD);
        is_store = (op_i == OP_STORE);
        ld_ok    = is_load && (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                               funct3_i == 3'b010 || funct3_i == 3'b100 ||
                               funct3_i == 3'b101);
        st_ok    = is_store && (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                                funct3_i == 3'b010);
    end

    // Index of the final byte for the latched size, plus load result extension.
    always_comb begin
        case (req_q.funct3[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        case (req_q.funct3)
            3'b000:  ld_result = {{24{buf_q[7]}}, buf_q[7:0]};
            3'b001:  ld_result = {{16{buf_q[15]}}, buf_q[15:0]};
            3'b100:  ld_result = {24'b0, buf_q[7:0]};
            3'b101:  ld_result = {16'b0, buf_q[15:0]};
            default: ld_result = buf_q;
        endcase
    end

    // Next-state and output logic; reset forces every output low.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        stallreq_o  = 1'b0;
        wd_o        = 5'b0;
        wreg_o      = 1'b0;
        wdata_o     = 32'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'b0;
        mem_wdata_o = 8'b0;

        case (state_q)
            IDLE: begin
                if (ld_ok || st_ok) begin
                    stallreq_o     = 1'b1;
                    req_d.is_store = is_store;
                    req_d.funct3   = funct3_i;
                    req_d.addr     = mem_addr_i;
                    req_d.sdata    = reg_i;
                    req_d.wd       = wd_i;
                    req_d.wreg     = wreg_i;
                    idx_d          = 2'd0;
                    buf_d          = 32'b0;
                    state_d        = ACCESS;
                end else if (!is_load && !is_store) begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
                // Memory op with an illegal size: squash to a null writeback.
            end
            ACCESS: begin
                stallreq_o  = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = req_q.is_store;
                mem_addr_o  = req_q.addr + {30'b0, idx_q};
                mem_wdata_o = req_q.sdata[{idx_q, 3'b000} +: 8];
                if (mem_ready_i) begin
                    if (!req_q.is_store)
                        buf_d[{idx_q, 3'b000} +: 8] = mem_rdata_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == last_idx)
                        state_d = DONE;
                end
            end
            DONE: begin
                wd_o = req_q.wd;
                if (!req_q.is_store) begin
                    wreg_o  = req_q.wreg;
                    wdata_o = ld_result;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            stallreq_o  = 1'b0;
            wd_o        = 5'b0;
            wreg_o      = 1'b0;
            wdata_o     = 32'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = 32'b0;
            mem_wdata_o = 8'b0;
        end
    end

    // State, latched request, byte index and read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            idx_q   <= 2'd0;
            buf_q   <= 32'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule
